// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle control unit for the lab processor datapath.
// Decodes R/I/J/load-store instructions and sequences IR, accumulator, ALU
// result register, register file, memory handshake and program counter.
module cpu_ctrl_fsm #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NREG        = 8,
  parameter int unsigned IMM_SIGNED  = 0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       instruction,
  input  logic              zero_flag,
  input  logic              mem_ack,
  output logic              ir_en,
  output logic              a_en,
  output logic              g_en,
  output logic [NREG-1:0]   reg_en,
  output logic [3:0]        mux_sel,
  output logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] imm_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic              wb_sel,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [1:0] FMT_R    = 2'd0;
  localparam logic [1:0] FMT_I    = 2'd1;
  localparam logic [1:0] FMT_J    = 2'd2;
  localparam logic [1:0] FMT_LS   = 2'd3;
  localparam logic [3:0] SEL_IMM  = 4'd8;
  localparam logic [3:0] SEL_IDLE = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_MEM, S_WB, S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_taken;

  logic [1:0]       w_fmt;
  logic [2:0]       w_op;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs;
  logic [7:0]       w_imm;
  logic             w_rd_ok;
  logic             w_rs_ok;
  logic [3:0]       w_rd_sel;
  logic [3:0]       w_rs_sel;
  logic [NREG-1:0]  w_rd_onehot;
  logic             w_jump_taken;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_imm_zext;

  // Instruction field decode and register-index range checks
  assign w_fmt        = instruction[1:0];
  assign w_op         = instruction[4:2];
  assign w_rd         = instruction[15:13];
  assign w_rs         = instruction[12:10];
  assign w_imm        = instruction[12:5];
  assign w_rd_ok      = 32'(w_rd) < NREG;
  assign w_rs_ok      = 32'(w_rs) < NREG;
  assign w_rd_sel     = w_rd_ok ? 4'(w_rd) : SEL_IDLE;
  assign w_rs_sel     = w_rs_ok ? 4'(w_rs) : SEL_IDLE;
  assign w_rd_onehot  = w_rd_ok ? (NREG'(1) << w_rd) : '0;
  assign w_jump_taken = !w_op[0] || zero_flag;
  assign w_imm_zext   = DATA_W'(w_imm);
  assign w_imm_ext    = (IMM_SIGNED != 0) ? DATA_W'($signed(w_imm)) : w_imm_zext;

  // State sequencing, MEM cycle counter, sticky timeout and taken-jump flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_taken <= 1'b0;
    end else if (run) begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: begin
          r_cnt   <= '0;
          r_taken <= 1'b0;
          case (w_fmt)
            FMT_J:   r_state <= S_EXEC;
            FMT_LS:  r_state <= S_MEM;
            default: r_state <= S_LOAD;
          endcase
        end
        S_LOAD:  r_state <= S_EXEC;
        S_EXEC: begin
          if (w_fmt == FMT_J) begin
            r_state <= S_DONE;
            r_taken <= w_jump_taken;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_state <= S_WB;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WB:    r_state <= S_DONE;
        S_DONE:  r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state, instruction and run; idle values when run is low
  always_comb begin
    ir_en       = 1'b0;
    a_en        = 1'b0;
    g_en        = 1'b0;
    reg_en      = '0;
    mux_sel     = SEL_IDLE;
    alu_sel     = 3'd0;
    imm_val     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    wb_sel      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    timeout_err = r_err;
    if (run) begin
      case (r_state)
        S_FETCH: ir_en = 1'b1;
        S_LOAD: begin
          a_en    = 1'b1;
          mux_sel = w_rd_sel;
        end
        S_EXEC: begin
          if (w_fmt == FMT_J) begin
            imm_val = w_imm_zext;
            pc_load = w_jump_taken;
          end else begin
            g_en    = 1'b1;
            alu_sel = w_op;
            if (w_fmt == FMT_I) begin
              mux_sel = SEL_IMM;
              imm_val = w_imm_ext;
            end else begin
              mux_sel = w_rs_sel;
            end
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = w_op[0];
          if (w_op[0]) mux_sel = w_rd_sel;
        end
        S_WB: begin
          if (w_fmt == FMT_LS) begin
            wb_sel = 1'b1;
            if (!w_op[0]) reg_en = w_rd_onehot;
          end else begin
            reg_en = w_rd_onehot;
          end
        end
        S_DONE: begin
          done   = 1'b1;
          pc_inc = !r_taken;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed testbench for cpu_ctrl_fsm: two instances share stimulus,
// dut_a (NREG=8, signed immediate) and dut_b (NREG=4, unsigned immediate).
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic        zero_flag;
  logic        mem_ack;

  logic        ir_en_a, a_en_a, g_en_a, mem_req_a, mem_we_a, wb_sel_a;
  logic        pc_inc_a, pc_load_a, done_a, busy_a, timeout_err_a;
  logic [7:0]  reg_en_a;
  logic [3:0]  mux_sel_a;
  logic [2:0]  alu_sel_a;
  logic [15:0] imm_val_a;

  logic        ir_en_b, a_en_b, g_en_b, mem_req_b, mem_we_b, wb_sel_b;
  logic        pc_inc_b, pc_load_b, done_b, busy_b, timeout_err_b;
  logic [3:0]  reg_en_b;
  logic [3:0]  mux_sel_b;
  logic [2:0]  alu_sel_b;
  logic [15:0] imm_val_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.DATA_W(16), .NREG(8), .IMM_SIGNED(1), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .zero_flag(zero_flag), .mem_ack(mem_ack),
    .ir_en(ir_en_a), .a_en(a_en_a), .g_en(g_en_a), .reg_en(reg_en_a),
    .mux_sel(mux_sel_a), .alu_sel(alu_sel_a), .imm_val(imm_val_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .wb_sel(wb_sel_a),
    .pc_inc(pc_inc_a), .pc_load(pc_load_a), .done(done_a), .busy(busy_a),
    .timeout_err(timeout_err_a)
  );

  cpu_ctrl_fsm #(.DATA_W(16), .NREG(4), .IMM_SIGNED(0), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .zero_flag(zero_flag), .mem_ack(mem_ack),
    .ir_en(ir_en_b), .a_en(a_en_b), .g_en(g_en_b), .reg_en(reg_en_b),
    .mux_sel(mux_sel_b), .alu_sel(alu_sel_b), .imm_val(imm_val_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .wb_sel(wb_sel_b),
    .pc_inc(pc_inc_b), .pc_load(pc_load_b), .done(done_b), .busy(busy_b),
    .timeout_err(timeout_err_b)
  );

  function automatic logic [15:0] mk(input logic [1:0] fmt, input logic [2:0] op,
                                     input logic [2:0] rd, input logic [7:0] imm);
    return {rd, imm, op, fmt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; instruction = '0; zero_flag = 1'b0; mem_ack = 1'b0;
    #2;
    chk("rst_ir_en",   32'(ir_en_a), 32'h0);
    chk("rst_mux_sel", 32'(mux_sel_a), 32'hF);
    chk("rst_busy",    32'(busy_a), 32'h0);
    chk("rst_tmo",     32'(timeout_err_a), 32'h0);
    @(negedge clk);
    // R add: rd=2, rs=5
    instruction = mk(2'b00, 3'b000, 3'd2, 8'hA0);
    reset = 1'b0;
    tick(); // IDLE -> FETCH (cycle 1)
    chk("r_fetch_ir_en", 32'(ir_en_a), 32'h1);
    chk("r_fetch_busy",  32'(busy_a), 32'h1);
    tick(); // LOAD
    chk("r_load_a_en",   32'(a_en_a), 32'h1);
    chk("r_load_mux",    32'(mux_sel_a), 32'h2);
    tick(); // EXEC
    chk("r_exec_g_en",   32'(g_en_a), 32'h1);
    chk("r_exec_mux",    32'(mux_sel_a), 32'h5);
    chk("r_exec_mux_b",  32'(mux_sel_b), 32'hF);
    chk("r_exec_alu",    32'(alu_sel_a), 32'h0);
    tick(); // WB
    chk("r_wb_reg_en",   32'(reg_en_a), 32'h04);
    chk("r_wb_wb_sel",   32'(wb_sel_a), 32'h0);
    tick(); // DONE (cycle 5)
    chk("r_done",        32'(done_a), 32'h1);
    chk("r_done_pc_inc", 32'(pc_inc_a), 32'h1);

    // rd=5 out of range on dut_b (NREG=4), op=2
    instruction = mk(2'b00, 3'b010, 3'd5, 8'h20);
    tick(); tick(); // FETCH, LOAD
    chk("oor_load_mux_a", 32'(mux_sel_a), 32'h5);
    chk("oor_load_mux_b", 32'(mux_sel_b), 32'hF);
    tick(); // EXEC
    chk("oor_exec_alu",   32'(alu_sel_b), 32'h2);
    chk("oor_exec_mux_b", 32'(mux_sel_b), 32'h1);
    tick(); // WB
    chk("oor_wb_reg_a",   32'(reg_en_a), 32'h20);
    chk("oor_wb_reg_b",   32'(reg_en_b), 32'h0);
    tick(); // DONE
    chk("oor_done_b",     32'(done_b), 32'h1);

    // I-type, imm=F0, op=1, rd=1
    instruction = mk(2'b01, 3'b001, 3'd1, 8'hF0);
    tick(); tick(); // FETCH, LOAD
    chk("i_load_mux",     32'(mux_sel_a), 32'h1);
    tick(); // EXEC
    chk("i_exec_imm_s",   32'(imm_val_a), 32'hFFF0);
    chk("i_exec_imm_u",   32'(imm_val_b), 32'h00F0);
    chk("i_exec_mux",     32'(mux_sel_a), 32'h8);
    chk("i_exec_alu",     32'(alu_sel_a), 32'h1);
    tick(); // WB
    chk("i_wb_reg_en",    32'(reg_en_a), 32'h02);
    tick(); // DONE
    chk("i_done",         32'(done_a), 32'h1);

    // J conditional taken
    instruction = mk(2'b10, 3'b001, 3'd0, 8'hA0);
    zero_flag = 1'b1;
    tick(); // FETCH
    chk("jt_fetch",       32'(ir_en_a), 32'h1);
    tick(); // EXEC
    chk("jt_pc_load",     32'(pc_load_a), 32'h1);
    chk("jt_imm_zext",    32'(imm_val_a), 32'h00A0);
    chk("jt_exec_pc_inc", 32'(pc_inc_a), 32'h0);
    tick(); // DONE (cycle 3)
    chk("jt_done",        32'(done_a), 32'h1);
    chk("jt_done_pc_inc", 32'(pc_inc_a), 32'h0);

    // J conditional not taken
    zero_flag = 1'b0;
    tick(); tick(); // FETCH, EXEC
    chk("jn_pc_load",     32'(pc_load_a), 32'h0);
    tick(); // DONE
    chk("jn_done",        32'(done_a), 32'h1);
    chk("jn_pc_inc",      32'(pc_inc_a), 32'h1);

    // J unconditional with zero_flag low
    instruction = mk(2'b10, 3'b000, 3'd0, 8'h11);
    tick(); tick(); // FETCH, EXEC
    chk("ju_pc_load",     32'(pc_load_a), 32'h1);
    tick(); // DONE
    chk("ju_pc_inc",      32'(pc_inc_a), 32'h0);

    // Load rd=7, ack in third MEM cycle
    instruction = mk(2'b11, 3'b000, 3'd7, 8'h00);
    tick(); // FETCH (1)
    tick(); // MEM (2)
    chk("ld_mem1_req",    32'(mem_req_a), 32'h1);
    chk("ld_mem1_we",     32'(mem_we_a), 32'h0);
    chk("ld_mem1_mux",    32'(mux_sel_a), 32'hF);
    tick(); // MEM (3)
    chk("ld_mem2_req",    32'(mem_req_a), 32'h1);
    tick(); // MEM (4)
    mem_ack = 1'b1;
    #1;
    chk("ld_mem3_req",    32'(mem_req_a), 32'h1);
    tick(); // WB (5)
    mem_ack = 1'b0;
    #1;
    chk("ld_wb_reg_en",   32'(reg_en_a), 32'h80);
    chk("ld_wb_reg_en_b", 32'(reg_en_b), 32'h0);
    chk("ld_wb_sel",      32'(wb_sel_a), 32'h1);
    chk("ld_wb_req",      32'(mem_req_a), 32'h0);
    tick(); // DONE (6)
    chk("ld_done",        32'(done_a), 32'h1);
    chk("ld_tmo",         32'(timeout_err_a), 32'h0);

    // Store rd=3 with no ack: timeout after 4 MEM cycles
    instruction = mk(2'b11, 3'b001, 3'd3, 8'h00);
    tick(); // FETCH
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_mem_req",   32'(mem_req_a), 32'h1);
      chk("st_mem_we",    32'(mem_we_a), 32'h1);
      chk("st_mem_mux",   32'(mux_sel_a), 32'h3);
    end
    tick(); // DONE
    chk("st_tmo_req",     32'(mem_req_a), 32'h0);
    chk("st_tmo_done",    32'(done_a), 32'h1);
    chk("st_tmo_err",     32'(timeout_err_a), 32'h1);
    chk("st_tmo_reg_en",  32'(reg_en_a), 32'h0);
    chk("st_tmo_pc_inc",  32'(pc_inc_a), 32'h1);

    // Reset during MEM clears everything
    instruction = mk(2'b11, 3'b000, 3'd4, 8'h00);
    tick(); // FETCH
    chk("tmo_sticky",     32'(timeout_err_a), 32'h1);
    tick(); tick(); // MEM, MEM
    chk("rm_req_before",  32'(mem_req_a), 32'h1);
    reset = 1'b1;
    #1;
    chk("rm_req",         32'(mem_req_a), 32'h0);
    chk("rm_mux",         32'(mux_sel_a), 32'hF);
    chk("rm_busy",        32'(busy_a), 32'h0);
    chk("rm_tmo",         32'(timeout_err_a), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick(); // FETCH
    chk("rm_refetch",     32'(ir_en_a), 32'h1);

    // Ack in the MEM_TIMEOUT-th cycle wins over timeout
    tick(); tick(); tick(); // MEM 1..3
    tick(); // MEM 4
    mem_ack = 1'b1;
    #1;
    chk("edge_mem4_req",  32'(mem_req_a), 32'h1);
    tick(); // WB
    mem_ack = 1'b0;
    #1;
    chk("edge_wb_reg_en", 32'(reg_en_a), 32'h10);
    chk("edge_wb_tmo",    32'(timeout_err_a), 32'h0);
    tick(); // DONE
    chk("edge_done",      32'(done_a), 32'h1);
    chk("edge_done_tmo",  32'(timeout_err_a), 32'h0);

    // run dropped mid-EXEC for 3 cycles
    instruction = mk(2'b00, 3'b011, 3'd3, 8'h40);
    tick(); tick(); tick(); // FETCH, LOAD, EXEC
    chk("run_exec_g_en",  32'(g_en_a), 32'h1);
    run = 1'b0;
    #1;
    chk("run0_g_en",      32'(g_en_a), 32'h0);
    chk("run0_mux",       32'(mux_sel_a), 32'hF);
    chk("run0_alu",       32'(alu_sel_a), 32'h0);
    chk("run0_busy",      32'(busy_a), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run0_hold_g_en", 32'(g_en_a), 32'h0);
      chk("run0_hold_done", 32'(done_a), 32'h0);
    end
    run = 1'b1;
    #1;
    chk("run1_g_en",      32'(g_en_a), 32'h1);
    chk("run1_mux",       32'(mux_sel_a), 32'h2);
    chk("run1_alu",       32'(alu_sel_a), 32'h3);
    tick(); // WB
    chk("run1_wb_reg_en", 32'(reg_en_a), 32'h08);
    tick(); // DONE
    chk("run1_done",      32'(done_a), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Parametrised multicycle control unit for the lab processor datapath. It decodes 16-bit instructions of four formats: R, I, J and load/store. It sequences the instruction register, accumulator, ALU result register, register file, memory port and program counter. It adds three things over the fixed 8-register design:

- configurable data width and register count;
- J-type jumps, both unconditional and zero-conditional;
- a req/ack memory handshake with a timeout.

## Interface
Parameters:
- DATA_W, 16: datapath width. Width of imm_val.
- NREG, 8: number of general registers, legal range 2..8. Width of reg_en.
- IMM_SIGNED, 0: 1 sign-extends the 8-bit immediate to DATA_W; 0 zero-extends it.
- MEM_TIMEOUT, 15: maximum number of cycles mem_req is held without mem_ack. Legal range ≥1.

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- run  in  1  advance enable. While low, the state holds and all outputs take their idle values.
- instruction  in  16  fields: fmt=[1:0], op=[4:2], rd=[15:13], rs=[12:10], imm=[12:5].
- zero_flag  in  1  ALU zero status, used by conditional jumps.
- mem_ack  in  1  memory completion for the current request.
- ir_en  out  1  load the instruction register.
- a_en  out  1  load the accumulator (operand A).
- g_en  out  1  load the ALU result register.
- reg_en  out  NREG  one-hot register write enable.
- mux_sel  out  4  bus source select: 0..NREG-1 selects a register, 8 selects the immediate, 15 is idle.
- alu_sel  out  3  ALU operation; equals op.
- imm_val  out  DATA_W  extended immediate.
- mem_req, mem_we  out  1  memory request and write strobe.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = memory.
- pc_inc, pc_load  out  1  increment the PC, or load the PC from imm_val.
- done  out  1  one-cycle pulse at instruction completion.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky memory timeout flag.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, MEM, WB, DONE. Transitions occur only on a clk edge with run=1.
- IDLE goes to FETCH. FETCH asserts ir_en.
- After FETCH, the next state depends on fmt:
  - R and I go to LOAD;
  - J goes to EXEC;
  - load/store goes to MEM.
- R and I path:
  - LOAD: mux_sel=rd, a_en=1.
  - EXEC: for R, mux_sel=rs. For I, mux_sel=8 and imm_val is the extended immediate. g_en=1, alu_sel=op.
  - WB: reg_en[rd]=1, wb_sel=0.
- J path (EXEC): imm_val is the zero-extended immediate.
  - op[0]=0: pc_load=1.
  - op[0]=1: pc_load=zero_flag.
  - The next state is DONE, and pc_inc is not asserted.
- Load/store path: op[0]=0 is a load, 1 is a store.
  - MEM: mem_req=1, mem_we=op[0], mux_sel=rd when storing.
  - mem_ack=1 goes to WB.
  - Otherwise MEM is held, counting cycles spent in MEM. Without mem_ack, the state leaves MEM to DONE after MEM_TIMEOUT cycles. timeout_err is set, and no register write occurs.
  - WB for a load: reg_en[rd]=1, wb_sel=1. WB for a store: no reg_en, wb_sel=1.
- WB goes to DONE.
- DONE: done=1. pc_inc=1 unless the instruction is a taken jump. Then goes to FETCH.
- An rd or rs value ≥ NREG produces no reg_en bit and mux_sel=15. The instruction otherwise completes normally.
- All outputs are combinational decodes of the state, the instruction and run. Each output not named above holds its idle value:
  - mux_sel=15;
  - imm_val=0;
  - all other outputs 0;
  - busy and timeout_err are the exceptions and always reflect their state.

## Timing
- Reset (asynchronous, any state, including mid-MEM):
  - state goes to IDLE;
  - the timeout counter is cleared;
  - timeout_err=0;
  - all outputs take their idle values in the same cycle.
- Latency in cycles with run held high, counted from FETCH to the done pulse inclusive:
  - R or I: 5;
  - J: 3;
  - load/store: 4 + (number of MEM cycles − 1).
- mem_ack is sampled only in MEM. If mem_ack is high in the first MEM cycle, MEM lasts exactly one cycle. mem_ack outside MEM is ignored.
- Timeout and ack together: when mem_ack arrives in the MEM_TIMEOUT-th cycle, the ack wins and timeout_err stays 0.
- run=0 in any state, including MEM:
  - the state freezes;
  - the timeout counter freezes;
  - outputs go idle, including mem_req.
- The memory must hold its ack until it observes mem_req again.
- timeout_err clears only on reset.

## Test plan
- R add: with DATA_W=16, issue fmt=00, op=000, rd=2, rs=5. Required: ir_en at cycle 1; a_en with mux_sel=2; g_en with mux_sel=5 and alu_sel=0; reg_en=8'b00000100; done at cycle 5.
- I signed: with IMM_SIGNED=1, issue imm=8'hF0, op=001. Required: imm_val=16'hFFF0 and mux_sel=8 in EXEC. With IMM_SIGNED=0: imm_val=16'h00F0.
- J conditional: issue op[0]=1, imm=8'h20. With zero_flag=1: pc_load=1, imm_val=16'h0020, no pc_inc, done at cycle 3. With zero_flag=0: pc_load=0, and pc_inc=1 in DONE.
- Load with 3-cycle ack delay: issue rd=7. Required: mem_req held for 3 cycles with mem_we=0; then reg_en[7]=1 with wb_sel=1; done at cycle 6.
- Store timeout: with MEM_TIMEOUT=4, mem_ack held 0. Required: mem_req high for exactly 4 cycles; timeout_err=1 and staying 1; no reg_en; done pulses. A subsequent reset clears timeout_err.
- Reset and run: assert reset in MEM. Required: all outputs idle immediately, and mux_sel=15. Separately, drop run mid-EXEC for 3 cycles. Required: the state holds, and the instruction resumes and completes with unchanged latency plus 3.
